audio_frame_sequencer: RTL and testbench

- Host-side master for the AudioProcessor frame interface.
- Streams source lines into the processor's 64-beat input buffer, pulses start, waits for done, then drains the 64-beat output buffer to a downstream sink with backpressure.
- Repeats for a programmed number of frames.
- Sits between an audio sample source (storage/DMA) and the processor, replacing the bench-driven fill/start/read sequencing.

---
 rtl/audio_pkg.sv | 18 +
 rtl/seq_out_reg.sv | 57 +++++
 rtl/audio_frame_sequencer.sv | 172 +++++++++++++++++
 tb/tb_audio_frame_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared constants and state encoding for the audio frame sequencer.
package audio_pkg;

   localparam int unsigned AUDIO_LINE_W = 512;
   localparam int unsigned AUDIO_BEATS  = 64;
   localparam int unsigned AUDIO_IDX_W  = 6;
   localparam int unsigned AUDIO_FRM_W  = 16;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      START,
      WAIT,
      DRAIN,
      NEXT
   } seq_state_t;

endpackage

// File: rtl/seq_out_reg.sv
// One-entry valid/ready output register feeding the downstream sink.
module seq_out_reg
   import audio_pkg::*;
#(
   parameter int unsigned DATA_W = AUDIO_LINE_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              last_i,
   input  logic              ready_i,
   output logic              can_load_o,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic              last_o
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              last_q, last_d;

   // Slot is free when empty or when its current beat is being popped.
   assign can_load_o = !valid_q || ready_i;

   // Next entry: a load replaces the slot, a bare pop empties it, otherwise hold.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
         last_d  = last_i;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
   end

   // Entry register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign last_o  = last_q;

endmodule

// File: rtl/audio_frame_sequencer.sv
// Host-side master: fills the processor input buffer, starts it, waits for a
// fresh done edge, drains the output buffer to the sink, repeats per frame.
module audio_frame_sequencer
   import audio_pkg::*;
#(
   parameter int unsigned DATA_W = AUDIO_LINE_W,
   parameter int unsigned BEATS  = AUDIO_BEATS,
   parameter int unsigned IDX_W  = AUDIO_IDX_W,
   parameter int unsigned FRM_W  = AUDIO_FRM_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              go_i,
   input  logic [FRM_W-1:0]  cfg_num_frames_i,
   output logic              busy_o,
   output logic              run_done_o,
   output logic [FRM_W-1:0]  frames_done_o,
   input  logic              src_valid_i,
   output logic              src_ready_o,
   input  logic [DATA_W-1:0] src_data_i,
   output logic              proc_data_wr_en_o,
   output logic [IDX_W-1:0]  proc_input_index_o,
   output logic [DATA_W-1:0] proc_data_in_o,
   output logic              proc_start_o,
   input  logic              proc_done_i,
   output logic [IDX_W-1:0]  proc_output_index_o,
   input  logic [DATA_W-1:0] proc_data_out_i,
   output logic              snk_valid_o,
   input  logic              snk_ready_i,
   output logic [DATA_W-1:0] snk_data_o,
   output logic              snk_last_o
);

   localparam logic [IDX_W-1:0] LastIdx  = IDX_W'(BEATS - 1);
   localparam logic [IDX_W:0]   BeatsCnt = (IDX_W + 1)'(BEATS);

   seq_state_t       state_q, state_d;
   logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
   logic [IDX_W:0]   rd_idx_q, rd_idx_d;
   logic [FRM_W-1:0] num_frames_q, num_frames_d;
   logic [FRM_W-1:0] frames_done_q, frames_done_d;
   logic             busy_q, busy_d;
   logic             run_done_q, run_done_d;
   logic             done_q;

   logic             out_load;
   logic             out_can_load;
   logic             rd_is_last;

   assign rd_is_last = (rd_idx_q == {1'b0, LastIdx});

   // Next-state, counters and combinational processor/source handshake outputs.
   always_comb begin
      state_d             = state_q;
      wr_idx_d            = wr_idx_q;
      rd_idx_d            = rd_idx_q;
      num_frames_d        = num_frames_q;
      frames_done_d       = frames_done_q;
      busy_d              = busy_q;
      run_done_d          = 1'b0;
      src_ready_o         = 1'b0;
      proc_data_wr_en_o   = 1'b0;
      proc_input_index_o  = '0;
      proc_data_in_o      = '0;
      proc_start_o        = 1'b0;
      proc_output_index_o = '0;
      out_load            = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (go_i) begin
               num_frames_d  = cfg_num_frames_i;
               frames_done_d = '0;
               if (cfg_num_frames_i == '0) begin
                  run_done_d = 1'b1;
               end else begin
                  busy_d  = 1'b1;
                  state_d = FILL;
               end
            end
         end
         FILL: begin
            src_ready_o        = 1'b1;
            proc_data_wr_en_o  = src_valid_i;
            proc_input_index_o = wr_idx_q;
            proc_data_in_o     = src_data_i;
            if (src_valid_i) begin
               wr_idx_d = wr_idx_q + 1'b1;
               if (wr_idx_q == LastIdx) begin
                  wr_idx_d = '0;
                  state_d  = START;
               end
            end
         end
         START: begin
            proc_start_o = 1'b1;
            state_d      = WAIT;
         end
         WAIT: begin
            // Only a fresh rising edge counts; a level held over from the
            // previous frame must not trigger an early drain.
            if (proc_done_i && !done_q) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            proc_output_index_o = rd_idx_q[IDX_W-1:0];
            if (out_can_load && (rd_idx_q < BeatsCnt)) begin
               out_load = 1'b1;
               rd_idx_d = rd_idx_q + 1'b1;
            end
            if (snk_valid_o && snk_ready_i && snk_last_o) begin
               rd_idx_d = '0;
               state_d  = NEXT;
            end
         end
         NEXT: begin
            frames_done_d = frames_done_q + 1'b1;
            if (frames_done_d == num_frames_q) begin
               run_done_d = 1'b1;
               busy_d     = 1'b0;
               state_d    = IDLE;
            end else begin
               state_d = FILL;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and counter registers; done_q tracks proc_done in every state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         wr_idx_q      <= '0;
         rd_idx_q      <= '0;
         num_frames_q  <= '0;
         frames_done_q <= '0;
         busy_q        <= 1'b0;
         run_done_q    <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_idx_q      <= wr_idx_d;
         rd_idx_q      <= rd_idx_d;
         num_frames_q  <= num_frames_d;
         frames_done_q <= frames_done_d;
         busy_q        <= busy_d;
         run_done_q    <= run_done_d;
         done_q        <= proc_done_i;
      end
   end

   seq_out_reg #(
      .DATA_W(DATA_W)
   ) u_out_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (out_load),
      .data_i    (proc_data_out_i),
      .last_i    (rd_is_last),
      .ready_i   (snk_ready_i),
      .can_load_o(out_can_load),
      .valid_o   (snk_valid_o),
      .data_o    (snk_data_o),
      .last_o    (snk_last_o)
   );

   assign busy_o        = busy_q;
   assign run_done_o    = run_done_q;
   assign frames_done_o = frames_done_q;

endmodule

// File: tb/tb_audio_frame_sequencer.sv
// Randomized bench: behavioural processor, source and sink models with a
// line-order scoreboard for the audio frame sequencer.
module tb_audio_frame_sequencer;

   localparam int unsigned DATA_W = 512;
   localparam int unsigned BEATS  = 64;
   localparam int unsigned IDX_W  = 6;
   localparam int unsigned FRM_W  = 16;
   localparam int          DoneLat = 20;

   logic              clk;
   logic              rst_n;
   logic              go;
   logic [FRM_W-1:0]  cfg_num_frames;
   logic              busy_o, run_done_o;
   logic [FRM_W-1:0]  frames_done_o;
   logic              src_valid, src_ready_o;
   logic [DATA_W-1:0] src_data;
   logic              proc_data_wr_en_o, proc_start_o, proc_done;
   logic [IDX_W-1:0]  proc_input_index_o, proc_output_index_o;
   logic [DATA_W-1:0] proc_data_in_o, proc_data_out;
   logic              snk_valid_o, snk_ready, snk_last_o;
   logic [DATA_W-1:0] snk_data_o;

   audio_frame_sequencer #(
      .DATA_W(DATA_W),
      .BEATS (BEATS),
      .IDX_W (IDX_W),
      .FRM_W (FRM_W)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .go_i               (go),
      .cfg_num_frames_i   (cfg_num_frames),
      .busy_o             (busy_o),
      .run_done_o         (run_done_o),
      .frames_done_o      (frames_done_o),
      .src_valid_i        (src_valid),
      .src_ready_o        (src_ready_o),
      .src_data_i         (src_data),
      .proc_data_wr_en_o  (proc_data_wr_en_o),
      .proc_input_index_o (proc_input_index_o),
      .proc_data_in_o     (proc_data_in_o),
      .proc_start_o       (proc_start_o),
      .proc_done_i        (proc_done),
      .proc_output_index_o(proc_output_index_o),
      .proc_data_out_i    (proc_data_out),
      .snk_valid_o        (snk_valid_o),
      .snk_ready_i        (snk_ready),
      .snk_data_o         (snk_data_o),
      .snk_last_o         (snk_last_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_bad    = 0;

   task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                           input logic [DATA_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] rand_line();
      logic [DATA_W-1:0] v;
      for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Stimulus controls and scoreboard state.
   int                src_mode = 0;   // 0 full rate, 1 toggle, 2 random
   int                snk_mode = 0;   // 0 always ready, 1 stall at beat 10, 2 random
   int                stall_left = 0;
   bit                stale_done = 1'b0;
   logic [DATA_W-1:0] src_q[$];
   logic [DATA_W-1:0] exp_q[$];
   int                mon_beat = 0;
   int                wr_in_frame = 0;
   int                wr_total = 0, beats_total = 0, start_cnt = 0, run_done_cnt = 0;
   int                model_frames = 0;

   // Processor model: echoes its input buffer DoneLat cycles after start; in
   // stale mode done stays high for a few cycles after start before dropping.
   logic [DATA_W-1:0] in_buf [BEATS];
   logic [DATA_W-1:0] out_buf[BEATS];
   assign proc_data_out = out_buf[proc_output_index_o];

   initial begin : proc_model
      bit                p_wr, p_start;
      logic [IDX_W-1:0]  p_idx;
      logic [DATA_W-1:0] p_data;
      int                cnt, stale_cnt;
      proc_done = 1'b0;
      cnt       = 0;
      stale_cnt = 0;
      forever begin
         @(negedge clk);
         p_wr    = proc_data_wr_en_o && rst_n;
         p_idx   = proc_input_index_o;
         p_data  = proc_data_in_o;
         p_start = proc_start_o && rst_n;
         @(posedge clk);
         #1;
         if (p_wr) in_buf[p_idx] = p_data;
         if (p_start) begin
            cnt = DoneLat;
            if (stale_done) stale_cnt = 5;
            else proc_done = 1'b0;
         end else begin
            if (stale_cnt > 0) begin
               stale_cnt--;
               if (stale_cnt == 0) proc_done = 1'b0;
            end
            if (cnt > 0) begin
               cnt--;
               if (cnt == 0) begin
                  out_buf   = in_buf;
                  proc_done = 1'b1;
               end
            end
         end
      end
   end

   // Source driver: presents the head of src_q, pops it after each handshake.
   initial begin : src_drv
      bit hs;
      src_valid = 1'b0;
      src_data  = '0;
      forever begin
         @(negedge clk);
         hs = src_valid && src_ready_o && rst_n;
         @(posedge clk);
         #1;
         if (hs && src_q.size() > 0) void'(src_q.pop_front());
         if (src_q.size() > 0) begin
            src_data = src_q[0];
            if (src_mode == 0) src_valid = 1'b1;
            else if (src_mode == 1) src_valid = ~src_valid;
            else src_valid = ($urandom_range(0, 1) == 1);
         end else begin
            src_valid = 1'b0;
         end
      end
   end

   // Sink driver.
   initial begin : snk_drv
      snk_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (snk_mode == 0) begin
            snk_ready = 1'b1;
         end else if (snk_mode == 1) begin
            if (mon_beat < 10) snk_ready = 1'b1;
            else if (stall_left > 0) begin
               snk_ready = 1'b0;
               stall_left--;
            end else snk_ready = ~snk_ready;
         end else begin
            snk_ready = ($urandom_range(0, 3) != 0);
         end
      end
   end

   // Monitor: checks writes, start placement, sink order/hold and frame counts.
   logic              prev_stall = 1'b0, prev_start = 1'b0, prev_last = 1'b0;
   logic [DATA_W-1:0] prev_data = '0;
   logic [FRM_W-1:0]  prev_fd = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall  = 1'b0;
         prev_start  = 1'b0;
         prev_fd     = '0;
         mon_beat    = 0;
         wr_in_frame = 0;
         exp_q.delete();
      end else begin
         check_eq("wr_en", proc_data_wr_en_o, src_valid && src_ready_o);
         if (proc_start_o) begin
            check_eq("start_after_fill", wr_in_frame, BEATS);
            check_eq("start_one_cycle", prev_start, 1'b0);
            wr_in_frame = 0;
            start_cnt++;
         end
         prev_start = proc_start_o;
         if (proc_data_wr_en_o) begin
            check_eq("wr_idx", proc_input_index_o, wr_in_frame % BEATS);
            check_eq("wr_data", proc_data_in_o, src_data);
            wr_in_frame++;
            wr_total++;
         end
         if (src_valid && src_ready_o) exp_q.push_back(src_data);
         if (prev_stall) begin
            check_eq("hold_valid", snk_valid_o, 1'b1);
            check_eq("hold_data", snk_data_o, prev_data);
            check_eq("hold_last", snk_last_o, prev_last);
         end
         if (snk_valid_o && snk_ready) begin
            check_eq("snk_avail", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check_eq("snk_data", snk_data_o, exp_q.pop_front());
            check_eq("snk_last", snk_last_o, mon_beat == BEATS - 1);
            if (mon_beat == BEATS - 1) model_frames++;
            mon_beat = (mon_beat + 1) % BEATS;
            beats_total++;
         end
         prev_stall = snk_valid_o && !snk_ready;
         prev_data  = snk_data_o;
         prev_last  = snk_last_o;
         if (frames_done_o != prev_fd && frames_done_o != '0)
            check_eq("frames_step", frames_done_o, model_frames);
         prev_fd = frames_done_o;
         if (run_done_o) run_done_cnt++;
      end
   end

   task automatic check_idle_outputs();
      check_eq("rst_busy", busy_o, 1'b0);
      check_eq("rst_run_done", run_done_o, 1'b0);
      check_eq("rst_frames_done", frames_done_o, '0);
      check_eq("rst_src_ready", src_ready_o, 1'b0);
      check_eq("rst_wr_en", proc_data_wr_en_o, 1'b0);
      check_eq("rst_in_idx", proc_input_index_o, '0);
      check_eq("rst_data_in", proc_data_in_o, '0);
      check_eq("rst_start", proc_start_o, 1'b0);
      check_eq("rst_out_idx", proc_output_index_o, '0);
      check_eq("rst_snk_valid", snk_valid_o, 1'b0);
      check_eq("rst_snk_data", snk_data_o, '0);
      check_eq("rst_snk_last", snk_last_o, 1'b0);
   endtask

   task automatic do_run(input int cfg, input bit idx_lines, input int sm, input int km,
                         input bit stale, input bit extra_go);
      int rd0, st0, wr0, bt0;
      bit got;
      for (int f = 0; f < cfg; f++)
         for (int k = 0; k < BEATS; k++)
            src_q.push_back(idx_lines ? DATA_W'(k) : rand_line());
      src_mode     = sm;
      snk_mode     = km;
      stale_done   = stale;
      stall_left   = 5;
      model_frames = 0;
      rd0 = run_done_cnt;
      st0 = start_cnt;
      wr0 = wr_total;
      bt0 = beats_total;
      @(posedge clk);
      #1;
      cfg_num_frames = FRM_W'(cfg);
      go             = 1'b1;
      @(posedge clk);
      #1;
      go             = 1'b0;
      cfg_num_frames = FRM_W'($urandom);
      check_eq("busy_after_go", busy_o, cfg != 0);
      if (extra_go) begin
         repeat (100) @(posedge clk);
         #1;
         cfg_num_frames = FRM_W'(5);
         go             = 1'b1;
         @(posedge clk);
         #1;
         go = 1'b0;
      end
      got = 1'b0;
      for (int i = 0; i < 8000 && !got; i++) begin
         @(negedge clk);
         if (run_done_o) got = 1'b1;
      end
      check_eq("run_done_seen", got, 1'b1);
      repeat (4) @(negedge clk);
      check_eq("end_frames_done", frames_done_o, cfg);
      check_eq("end_busy", busy_o, 1'b0);
      check_eq("run_done_count", run_done_cnt - rd0, 1);
      check_eq("start_count", start_cnt - st0, cfg);
      check_eq("write_count", wr_total - wr0, cfg * BEATS);
      check_eq("beat_count", beats_total - bt0, cfg * BEATS);
      check_eq("exp_empty", exp_q.size(), 0);
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation exceeded its cycle budget");
      $fatal(1);
   end

   initial begin : main
      bit seen;
      rst_n          = 1'b0;
      go             = 1'b0;
      cfg_num_frames = '0;
      #22;
      check_idle_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      do_run(1, 1'b1, 0, 0, 1'b0, 1'b0);  // full rate, index-valued lines
      do_run(1, 1'b0, 1, 0, 1'b0, 1'b0);  // source gaps
      do_run(1, 1'b0, 0, 1, 1'b0, 1'b0);  // sink backpressure at beat 10
      do_run(3, 1'b0, 2, 2, 1'b1, 1'b0);  // stale done level across frames
      do_run(0, 1'b0, 0, 0, 1'b0, 1'b0);  // empty run
      do_run(2, 1'b0, 0, 0, 1'b0, 1'b1);  // go while busy is ignored

      // Reset in the middle of a drain, then a clean run.
      src_q.delete();
      for (int k = 0; k < BEATS; k++) src_q.push_back(rand_line());
      src_mode   = 0;
      snk_mode   = 0;
      stale_done = 1'b0;
      @(posedge clk);
      #1;
      cfg_num_frames = FRM_W'(1);
      go             = 1'b1;
      @(posedge clk);
      #1;
      go   = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 2000 && !seen; i++) begin
         @(negedge clk);
         if (mon_beat >= 30) seen = 1'b1;
      end
      check_eq("reached_beat_30", seen, 1'b1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle_outputs();
      src_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      do_run(1, 1'b0, 0, 0, 1'b0, 1'b0);

      for (int r = 0; r < 3; r++)
         do_run($urandom_range(1, 2), 1'b0, $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(0, 1) == 1, 1'b0);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
